fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 101 ++++++++++
 tb/tb_fetch_unit.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch front end: credit-limited request issue, 2-entry {PC, inst} queue,
// redirect handling that discards stale in-flight responses.
module fetch_unit #(
    parameter int unsigned         DATA_LEN = 32,
    parameter logic [DATA_LEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                Stall_i,
    input  logic                Branch_i,
    input  logic [DATA_LEN-1:0] BranchPC_i,
    output logic                imem_req_o,
    output logic [DATA_LEN-1:0] imem_addr_o,
    input  logic                imem_ack_i,
    input  logic [DATA_LEN-1:0] imem_data_i,
    output logic [DATA_LEN-1:0] PC_o,
    output logic [DATA_LEN-1:0] inst_o,
    output logic                valid_o
);

    localparam logic [DATA_LEN-1:0] NOP_INST = DATA_LEN'(32'h0000_0033);

    logic [DATA_LEN-1:0] r_fetch_pc;
    logic [DATA_LEN-1:0] r_q_pc   [2];
    logic [DATA_LEN-1:0] r_q_inst [2];
    logic                r_q_head;
    logic [1:0]          r_q_count;
    logic [1:0]          r_outstanding;
    logic [1:0]          r_discard;

    logic                w_valid;
    logic                w_req;
    logic                w_ack;
    logic                w_push;
    logic                w_pop;
    logic                w_wr_idx;
    logic [2:0]          w_credit_used;
    logic [1:0]          w_out_after_ack;
    logic [DATA_LEN-1:0] w_ack_pc;
    logic [DATA_LEN-1:0] w_branch_pc;
    logic                w_unused_bpc_lsb;

    assign w_valid         = (r_q_count != 2'd0);
    assign w_credit_used   = {1'b0, r_q_count} + {1'b0, r_outstanding};
    assign w_req           = rst_i & ~Branch_i & (w_credit_used < 3'd2);
    assign w_ack           = imem_ack_i & (r_outstanding != 2'd0);
    assign w_push          = w_ack & ~Branch_i & (r_discard == 2'd0);
    assign w_pop           = w_valid & ~Stall_i & ~Branch_i;
    assign w_wr_idx        = r_q_head ^ r_q_count[0];
    assign w_out_after_ack = r_outstanding - {1'b0, w_ack};
    assign w_branch_pc     = {BranchPC_i[DATA_LEN-1:2], 2'b00};
    assign w_unused_bpc_lsb = ^BranchPC_i[1:0];

    // With no discards pending, every outstanding request is sequential and the
    // youngest was issued at fetch_pc-4, so the oldest sits outstanding*4 back.
    assign w_ack_pc = r_fetch_pc - DATA_LEN'({r_outstanding, 2'b00});

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_fetch_pc    <= RESET_PC;
            r_q_head      <= 1'b0;
            r_q_count     <= 2'd0;
            r_outstanding <= 2'd0;
            r_discard     <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                r_q_pc[i]   <= '0;
                r_q_inst[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_q_pc[w_wr_idx]   <= w_ack_pc;
                r_q_inst[w_wr_idx] <= imem_data_i;
            end
            if (Branch_i) begin
                r_q_count     <= 2'd0;
                r_outstanding <= w_out_after_ack;
                r_discard     <= w_out_after_ack;
                r_fetch_pc    <= w_branch_pc;
            end else begin
                r_q_count     <= r_q_count + {1'b0, w_push} - {1'b0, w_pop};
                r_outstanding <= w_out_after_ack + {1'b0, w_req};
                if (w_pop) begin
                    r_q_head <= ~r_q_head;
                end
                if (w_ack && (r_discard != 2'd0)) begin
                    r_discard <= r_discard - 2'd1;
                end
                if (w_req) begin
                    r_fetch_pc <= r_fetch_pc + DATA_LEN'(4);
                end
            end
        end
    end

    assign imem_req_o  = w_req;
    assign imem_addr_o = r_fetch_pc;
    assign valid_o     = w_valid;
    assign PC_o        = w_valid ? r_q_pc[r_q_head]   : r_fetch_pc;
    assign inst_o      = w_valid ? r_q_inst[r_q_head] : NOP_INST;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: in-order memory with variable latency plus a queue-based
// reference model of the fetch rules, checked every cycle.
module tb_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0033;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        Stall_i = 1'b0;
    logic        Branch_i = 1'b0;
    logic [31:0] BranchPC_i = '0;
    logic        imem_ack_i = 1'b0;
    logic [31:0] imem_data_i = '0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic [31:0] PC_o;
    logic [31:0] inst_o;
    logic        valid_o;

    int total = 0;
    int bad   = 0;

    always #5 clk_i = ~clk_i;

    fetch_unit #(.DATA_LEN(32), .RESET_PC(RST_PC)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .Stall_i    (Stall_i),
        .Branch_i   (Branch_i),
        .BranchPC_i (BranchPC_i),
        .imem_req_o (imem_req_o),
        .imem_addr_o(imem_addr_o),
        .imem_ack_i (imem_ack_i),
        .imem_data_i(imem_data_i),
        .PC_o       (PC_o),
        .inst_o     (inst_o),
        .valid_o    (valid_o)
    );

    // memory environment: pending request addresses and the cycle each may answer
    logic [31:0] mem_addr[$];
    int          mem_rdy[$];
    int          last_rdy = -1;
    int          cyc = 0;
    int          lat_min = 1;
    int          lat_max = 1;

    // reference model
    logic [31:0] m_pc;
    logic [31:0] mq_pc[$];
    logic [31:0] mq_inst[$];
    logic [31:0] m_out[$];
    int          m_disc;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0013;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = RST_PC;
        mq_pc.delete();
        mq_inst.delete();
        m_out.delete();
        m_disc = 0;
    endtask

    task automatic model_step(input logic st, input logic br, input logic [31:0] bpc,
                              input logic ack, input logic [31:0] dat);
        logic [31:0] a;
        logic        req_now;
        req_now = !br && ((mq_pc.size() + m_out.size()) < 2);
        if (!br && !st && mq_pc.size() > 0) begin
            void'(mq_pc.pop_front());
            void'(mq_inst.pop_front());
        end
        if (ack && m_out.size() > 0) begin
            a = m_out.pop_front();
            if (!br) begin
                if (m_disc > 0) m_disc--;
                else begin
                    mq_pc.push_back(a);
                    mq_inst.push_back(dat);
                end
            end
        end
        if (br) begin
            mq_pc.delete();
            mq_inst.delete();
            m_disc = m_out.size();
            m_pc   = {bpc[31:2], 2'b00};
        end else if (req_now) begin
            m_out.push_back(m_pc);
            m_pc = m_pc + 32'd4;
        end
    endtask

    task automatic cycle(input logic rst, input logic st, input logic br, input logic [31:0] bpc);
        logic        ack;
        logic        e_req;
        logic        e_valid;
        logic [31:0] e_pc;
        logic [31:0] e_inst;
        logic        o_req;
        logic [31:0] o_addr;
        int          rdy;
        @(negedge clk_i);
        if (rst && !rst_i) begin
            mem_addr.delete();
            mem_rdy.delete();
            last_rdy = cyc;
        end
        rst_i      = rst;
        Stall_i    = st;
        Branch_i   = br;
        BranchPC_i = bpc;
        if (!rst) model_reset();
        ack = (mem_rdy.size() > 0) && (mem_rdy[0] <= cyc);
        imem_ack_i  = ack;
        imem_data_i = ack ? mem_word(mem_addr[0]) : $urandom;
        #1;
        e_req   = rst && !br && ((mq_pc.size() + m_out.size()) < 2);
        e_valid = (mq_pc.size() > 0);
        e_pc    = e_valid ? mq_pc[0] : m_pc;
        e_inst  = e_valid ? mq_inst[0] : NOP;
        chk("req",   {31'b0, imem_req_o}, {31'b0, e_req});
        chk("addr",  imem_addr_o, m_pc);
        chk("valid", {31'b0, valid_o}, {31'b0, e_valid});
        chk("pc",    PC_o, e_pc);
        chk("inst",  inst_o, e_inst);
        chk("no_overflow", {31'b0, ((mem_addr.size() + mq_pc.size()) <= 2)}, 32'd1);
        o_req  = imem_req_o;
        o_addr = imem_addr_o;
        @(posedge clk_i);
        if (ack) begin
            void'(mem_addr.pop_front());
            void'(mem_rdy.pop_front());
        end
        if (o_req) begin
            rdy = cyc + int'($urandom_range(lat_max, lat_min));
            if (rdy <= last_rdy) rdy = last_rdy + 1;
            last_rdy = rdy;
            mem_addr.push_back(o_addr);
            mem_rdy.push_back(rdy);
        end
        if (rst) model_step(st, br, bpc, ack, imem_data_i);
        cyc++;
    endtask

    task automatic run(input int n, input logic st);
        for (int i = 0; i < n; i++) cycle(1'b1, st, 1'b0, 32'h0);
    endtask

    initial begin
        int found;
        model_reset();

        // reset state, then straight-line fetch with 1-cycle memory
        lat_min = 1; lat_max = 1;
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        run(12, 1'b0);

        // stall for 5 cycles, then resume
        run(5, 1'b1);
        run(8, 1'b0);

        // redirect with two requests in flight on a 3-cycle memory
        lat_min = 3; lat_max = 3;
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        chk("two_inflight", mem_addr.size(), 32'd2);
        cycle(1'b1, 1'b0, 1'b1, 32'h0000_0100);
        run(12, 1'b0);

        // branch coinciding with an ack and a stall
        run(2, 1'b0);
        found = 0;
        for (int i = 0; i < 20 && found == 0; i++) begin
            if (mem_rdy.size() > 0 && mem_rdy[0] <= cyc) begin
                cycle(1'b1, 1'b1, 1'b1, 32'h0000_0100);
                found = 1;
            end else begin
                cycle(1'b1, 1'b1, 1'b0, 32'h0);
            end
        end
        chk("br_ack_found", found, 32'd1);
        run(10, 1'b0);

        // misaligned target near the top of the address space wraps to zero
        lat_min = 1; lat_max = 1;
        cycle(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFE);
        run(10, 1'b0);

        // reset with one request outstanding; its late ack lands during reset
        lat_min = 3; lat_max = 3;
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        chk("one_inflight", mem_addr.size(), 32'd1);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b0, 32'h0);
        run(10, 1'b0);

        // randomized traffic
        lat_min = 1; lat_max = 4;
        for (int i = 0; i < 800; i++) begin
            cycle(($urandom_range(99, 0) != 0),
                  ($urandom_range(99, 0) < 30),
                  ($urandom_range(99, 0) < 6),
                  $urandom);
        end
        run(10, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
